// File: rtl/stopwatch_time_counter_if.sv
// Control pulses and time/status outputs of the stopwatch time-base.
// master drives the pulses; slave is the counter itself.
interface stopwatch_time_counter_if;
    logic        tick;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [23:0] disp_time;
    logic [23:0] live_time;
    logic        running;
    logic        lap_active;
    logic        overflow;

    modport master (
        output tick, start_stop, lap, clear,
        input  disp_time, live_time, running, lap_active, overflow
    );

    modport slave (
        input  tick, start_stop, lap, clear,
        output disp_time, live_time, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_time_counter.sv
// Six-digit BCD stopwatch time-base (mm:ss.cc) with a run/pause/lap/clear FSM.
// In LAP, the display shows a frozen lap register while the live count keeps running.
module stopwatch_time_counter #(
    parameter int unsigned MAX_MIN_TENS = 5,
    parameter bit          TICK_EN_ONLY = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    stopwatch_time_counter_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] LAP   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [23:0] live_q,  live_d;
    logic [23:0] lap_q,   lap_d;
    logic        ovf_q,   ovf_d;

    logic        counting;
    logic        carry;
    logic [23:0] inc_time;

    // Digit order from LSB: cs0, cs1, s0, s1, m0, m1.
    function automatic logic [3:0] digit_limit(input int unsigned idx);
        logic [3:0] lim;
        case (idx)
            3:       lim = 4'd5;
            5:       lim = 4'(MAX_MIN_TENS);
            default: lim = 4'd9;
        endcase
        return lim;
    endfunction

    always_comb begin
        counting = ((state_q == RUN) || (state_q == LAP)) && (bus.tick || !TICK_EN_ONLY);

        // Ripple carry: each digit at or above its limit rolls to 0 and passes the carry on.
        inc_time = live_q;
        carry    = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (carry) begin
                if (live_q[4*i +: 4] >= digit_limit(i)) begin
                    inc_time[4*i +: 4] = '0;
                end else begin
                    inc_time[4*i +: 4] = live_q[4*i +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        live_d  = live_q;
        lap_d   = lap_q;
        ovf_d   = ovf_q;

        if (bus.clear) begin
            state_d = IDLE;
            live_d  = '0;
            lap_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (counting) begin
                live_d = inc_time;
                if (carry) begin
                    ovf_d = 1'b1;
                end
            end

            if (bus.start_stop) begin
                case (state_q)
                    IDLE:    state_d = RUN;
                    RUN:     state_d = PAUSE;
                    LAP:     state_d = PAUSE;
                    default: state_d = RUN;
                endcase
            end else if (bus.lap) begin
                if (state_q == RUN) begin
                    state_d = LAP;
                    lap_d   = live_q;
                end else if (state_q == LAP) begin
                    state_d = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            live_q  <= '0;
            lap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            lap_q   <= lap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.live_time  = live_q;
    assign bus.disp_time  = (state_q == LAP) ? lap_q : live_q;
    assign bus.running    = (state_q == RUN) || (state_q == LAP);
    assign bus.lap_active = (state_q == LAP);
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter: a default instance plus a short-wrap,
// free-running instance (MAX_MIN_TENS=0, TICK_EN_ONLY=0) used for the wrap checks.
module tb_stopwatch_time_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    stopwatch_time_counter_if b ();
    stopwatch_time_counter_if bw ();

    stopwatch_time_counter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    stopwatch_time_counter #(
        .MAX_MIN_TENS (0),
        .TICK_EN_ONLY (1'b0)
    ) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bw.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input logic t, input logic ss, input logic l, input logic c);
        b.tick = t; b.start_stop = ss; b.lap = l; b.clear = c;
        @(posedge clk);
        #1;
        b.tick = 1'b0; b.start_stop = 1'b0; b.lap = 1'b0; b.clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step_w(input logic ss, input logic c);
        bw.start_stop = ss; bw.clear = c;
        @(posedge clk);
        #1;
        bw.start_stop = 1'b0; bw.clear = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if ({b.live_time, b.disp_time, b.running, b.lap_active, b.overflow} !== 51'd0) begin
            miscompares++;
            $display("FAIL reset: live=%h disp=%h run=%b lap=%b ovf=%b, required all zero",
                     b.live_time, b.disp_time, b.running, b.lap_active, b.overflow);
        end
        vectors++;
        if ({bw.live_time, bw.running, bw.overflow} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_w: live=%h run=%b ovf=%b, required all zero",
                     bw.live_time, bw.running, bw.overflow);
        end
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_count;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({b.live_time, b.running} !== {24'h000000, 1'b1}) begin
            miscompares++;
            $display("FAIL start: live=%h run=%b, required 000000 1", b.live_time, b.running);
        end
        ticks(123);
        vectors++;
        if ({b.live_time, b.disp_time, b.running, b.lap_active, b.overflow} !==
            {24'h000123, 24'h000123, 3'b100}) begin
            miscompares++;
            $display("FAIL count123: live=%h disp=%h run=%b lap=%b ovf=%b, required 000123 000123 1 0 0",
                     b.live_time, b.disp_time, b.running, b.lap_active, b.overflow);
        end
    endtask

    task automatic test_minute_carry;
        ticks(5876);
        vectors++;
        if (b.live_time !== 24'h005999) begin
            miscompares++;
            $display("FAIL pre_minute: live=%h, required 005999", b.live_time);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({b.live_time, b.disp_time, b.overflow} !== {24'h010000, 24'h010000, 1'b0}) begin
            miscompares++;
            $display("FAIL minute_carry: live=%h disp=%h ovf=%b, required 010000 010000 0",
                     b.live_time, b.disp_time, b.overflow);
        end
    endtask

    task automatic test_wrap;
        bw.tick = 1'b0; bw.lap = 1'b0;
        step_w(1'b1, 1'b0);
        vectors++;
        if ({bw.live_time, bw.running} !== {24'h000000, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_start: live=%h run=%b, required 000000 1", bw.live_time, bw.running);
        end
        repeat (59999) @(posedge clk);
        #1;
        vectors++;
        if ({bw.live_time, bw.overflow} !== {24'h095999, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_top: live=%h ovf=%b, required 095999 0", bw.live_time, bw.overflow);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({bw.live_time, bw.overflow} !== {24'h000000, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap: live=%h ovf=%b, required 000000 1", bw.live_time, bw.overflow);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bw.live_time, bw.overflow} !== {24'h000002, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_sticky: live=%h ovf=%b, required 000002 1", bw.live_time, bw.overflow);
        end
        step_w(1'b0, 1'b1);
        @(posedge clk);
        #1;
        vectors++;
        if ({bw.live_time, bw.overflow, bw.running} !== {24'h000000, 2'b00}) begin
            miscompares++;
            $display("FAIL wrap_clear: live=%h ovf=%b run=%b, required 000000 0 0",
                     bw.live_time, bw.overflow, bw.running);
        end
    endtask

    task automatic test_lap;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(500);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({b.disp_time, b.live_time, b.lap_active, b.running} !== {24'h000500, 24'h000500, 2'b11}) begin
            miscompares++;
            $display("FAIL lap_enter: disp=%h live=%h lap=%b run=%b, required 000500 000500 1 1",
                     b.disp_time, b.live_time, b.lap_active, b.running);
        end
        ticks(250);
        vectors++;
        if ({b.disp_time, b.live_time, b.lap_active} !== {24'h000500, 24'h000750, 1'b1}) begin
            miscompares++;
            $display("FAIL lap_frozen: disp=%h live=%h lap=%b, required 000500 000750 1",
                     b.disp_time, b.live_time, b.lap_active);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({b.disp_time, b.lap_active, b.running} !== {24'h000750, 2'b01}) begin
            miscompares++;
            $display("FAIL lap_release: disp=%h lap=%b run=%b, required 000750 0 1",
                     b.disp_time, b.lap_active, b.running);
        end
        // Lap with a coincident tick captures the pre-increment value.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({b.disp_time, b.live_time, b.lap_active} !== {24'h000750, 24'h000751, 1'b1}) begin
            miscompares++;
            $display("FAIL lap_tick: disp=%h live=%h lap=%b, required 000750 000751 1",
                     b.disp_time, b.live_time, b.lap_active);
        end
        ticks(3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({b.disp_time, b.live_time, b.lap_active, b.running} !== {24'h000754, 24'h000754, 2'b00}) begin
            miscompares++;
            $display("FAIL lap_to_pause: disp=%h live=%h lap=%b run=%b, required 000754 000754 0 0",
                     b.disp_time, b.live_time, b.lap_active, b.running);
        end
    endtask

    task automatic test_pause;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(9);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({b.live_time, b.running} !== {24'h000010, 1'b0}) begin
            miscompares++;
            $display("FAIL stop_tick: live=%h run=%b, required 000010 0", b.live_time, b.running);
        end
        ticks(5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({b.live_time, b.disp_time, b.running, b.lap_active} !== {24'h000010, 24'h000010, 2'b00}) begin
            miscompares++;
            $display("FAIL pause_hold: live=%h disp=%h run=%b lap=%b, required 000010 000010 0 0",
                     b.live_time, b.disp_time, b.running, b.lap_active);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({b.live_time, b.running} !== {24'h000011, 1'b1}) begin
            miscompares++;
            $display("FAIL resume: live=%h run=%b, required 000011 1", b.live_time, b.running);
        end
        // start_stop outranks lap: RUN goes to PAUSE, not LAP.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({b.running, b.lap_active} !== 2'b00) begin
            miscompares++;
            $display("FAIL ss_over_lap: run=%b lap=%b, required 0 0", b.running, b.lap_active);
        end
    endtask

    task automatic test_clear_priority;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1234);
        vectors++;
        if (b.live_time !== 24'h001234) begin
            miscompares++;
            $display("FAIL pre_clear: live=%h, required 001234", b.live_time);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if ({b.live_time, b.disp_time, b.running, b.lap_active, b.overflow} !== 51'd0) begin
            miscompares++;
            $display("FAIL clear_prio: live=%h disp=%h run=%b lap=%b ovf=%b, required all zero",
                     b.live_time, b.disp_time, b.running, b.lap_active, b.overflow);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({b.live_time, b.running, b.lap_active} !== 26'd0) begin
            miscompares++;
            $display("FAIL idle_ignore: live=%h run=%b lap=%b, required 000000 0 0",
                     b.live_time, b.running, b.lap_active);
        end
    endtask

    task automatic test_async_reset;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({b.live_time, b.disp_time, b.running, b.lap_active, b.overflow} !== 51'd0) begin
            miscompares++;
            $display("FAIL async_reset: live=%h disp=%h run=%b lap=%b ovf=%b, required all zero",
                     b.live_time, b.disp_time, b.running, b.lap_active, b.overflow);
        end
        #2 rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({b.live_time, b.running} !== 25'd0) begin
            miscompares++;
            $display("FAIL post_reset_idle: live=%h run=%b, required 000000 0", b.live_time, b.running);
        end
    endtask

    initial begin
        b.tick = 1'b0; b.start_stop = 1'b0; b.lap = 1'b0; b.clear = 1'b0;
        bw.tick = 1'b0; bw.start_stop = 1'b0; bw.lap = 1'b0; bw.clear = 1'b0;
        test_reset;
        test_count;
        test_minute_carry;
        test_wrap;
        test_lap;
        test_pause;
        test_clear_priority;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
Sequential time-base that produces the BCD digits consumed by the 4-bit digit comparators and display path of the digital stopwatch. It counts centiseconds, seconds and minutes as six cascaded BCD digits advanced by a 100 Hz tick. A start/stop/lap/clear control FSM drives the count, and a lap register can freeze the displayed value while counting continues.

Parameters:
MAX_MIN_TENS, 5, highest legal minutes-tens digit; the count wraps after MAX_MIN_TENS9:59.99
TICK_EN_ONLY, 1, 1 = count only on tick pulses; 0 = count every clock (simulation speed-up)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle 100 Hz advance pulse
start_stop  input  1  one-cycle pulse, toggles run/pause
lap  input  1  one-cycle pulse, freezes/releases display
clear  input  1  one-cycle pulse, returns to zero/idle
disp_time  output  24  displayed digits {m1,m0,s1,s0,cs1,cs0}, 4-bit BCD each
live_time  output  24  live count, same packing
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP
overflow  output  1  sticky wrap flag

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; live_time=0, lap register=0, disp_time=0, running=0, lap_active=0, overflow=0. All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- FSM states: IDLE, RUN, PAUSE, LAP.
  - IDLE: start_stop -> RUN; lap ignored.
  - RUN: start_stop -> PAUSE; lap -> LAP, capturing live_time into the lap register.
  - LAP: lap -> RUN (release); start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN; lap ignored.
  - Any state: clear -> IDLE, zeroing live_time, the lap register and overflow.
- Simultaneous pulses: priority is clear > start_stop > lap; lower-priority pulses in the same cycle are dropped.
- Counting:
  - Increment happens when the current (pre-transition) state is RUN or LAP and tick=1, or on every clock when TICK_EN_ONLY=0.
  - A tick coinciding with start_stop in RUN is counted.
  - A tick coinciding with clear is not counted.
- Latency: live_time reflects an increment one clock after the qualifying tick edge.
- Digit rules:
  - cs0 0-9; carries into cs1 0-9.
  - cs1 carries into s0 0-9; s0 into s1 0-5.
  - s1 carries into m0 0-9; m0 into m1 0..MAX_MIN_TENS.
  - Each digit resets to 0 when it carries.
  - Digits never hold values above their limit, and never hold non-BCD codes 10-15.
- Wrap: increment from MAX_MIN_TENS9:59.99 gives 00:00.00 and sets overflow=1. overflow stays set until clear or reset; counting continues.
- Lap capture: the lap register takes the pre-increment live_time on the cycle lap is accepted.
- disp_time: equals the lap register in LAP, otherwise equals live_time (including PAUSE, IDLE, and immediately after LAP -> PAUSE).
- running = state is RUN or LAP; lap_active = state is LAP.
- rst_n asserted mid-count: everything clears immediately, without waiting for clk. Deassertion is synchronised externally.

Test Plan:
1. Reset, start_stop, then 123 ticks -> live_time=disp_time=00:01.23 (0x000123); running=1.
2. From 00:59.99 in RUN, one tick -> 01:00.00 (0x010000) one clock later; overflow stays 0.
3. From 59:59.99 (0x595999), one tick -> 0x000000 and overflow=1. Further ticks count from zero; clear drops overflow to 0.
4. RUN at 00:05.00, lap, then 250 ticks -> disp_time=0x000500, live_time=0x000750, lap_active=1. Second lap -> disp_time=0x000750.
5. RUN: start_stop with a coincident tick at 0x000009 -> PAUSE with live_time=0x000010. Ticks in PAUSE -> no change. start_stop -> RUN resumes.
6. clear, start_stop and tick in the same cycle from RUN at 0x001234 -> IDLE, all zero, running=0. Async rst_n pulse between clock edges mid-RUN -> outputs zero before the next edge.
